nn_run_sequencer: RTL and testbench
===================================

# nn_run_sequencer

Sample-level controller for the fixed-point inference network (input fill channel → layer0 → layer1 → output channel). It buffers one sample of `N_IN` input words from an upstream stream and re-arms the network, because the network's `ack_network` stays high until reset. It then serves the network's word requests, raises `req`, and collects the `N_OUT` result words. The results leave on a downstream valid/ready stream. The block sits between the host/testbench streams and the network top, and is the only driver of the network's reset, fill and req inputs.

## Interface
- `N_IN`, 2, input words per sample
- `N_OUT`, 1, output words per sample
- `DW`, 8, signed data width
- `NRST_CYC`, 2, network reset pulse length in cycles (≥1)
- `TIMEOUT`, 255, maximum cycles allowed in FILL plus RUN before abort
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high; clock clk
- `in_valid`  in  1  upstream word valid
- `in_ready`  out  1  upstream word accepted when `in_valid & in_ready`
- `in_data`  in  DW  signed input word
- `net_rst`  out  1  network reset
- `net_fill`  out  1  network fill enable
- `net_word_req`  in  1  network pulse: current word consumed, advance to next
- `net_fill_data`  out  DW  word presented to the network
- `net_ack_fill`  in  1  network input channel full
- `net_req`  out  1  start network evaluation
- `net_ack`  in  1  network done (sticky until `net_rst`)
- `net_out_valid`  in  1  one-cycle result strobe
- `net_out_data`  in  DW  result word
- `out_valid`  out  1  downstream valid
- `out_ready`  in  1  downstream ready
- `out_data`  out  DW  result word
- `out_last`  out  1  final word of a sample
- `busy`  out  1  state ≠ IDLE
- `err_timeout`  out  1  sticky abort flag; cleared by `rst` only
- `sample_cnt`  out  16  completed samples, wraps at 2^16

## Operation
- FSM states: IDLE, LOAD, NRST, FILL, RUN, EMIT, ABORT.
- **IDLE**
  - `in_ready`=1.
  - A handshake writes `in_data` to `ibuf[0]`.
  - If `N_IN`=1, go to NRST; otherwise go to LOAD with `widx`=1.
- **LOAD**
  - `in_ready`=1; each handshake writes `ibuf[widx++]`.
  - The `N_IN`-th word goes to NRST.
- **NRST**
  - `net_rst`=1 for exactly `NRST_CYC` cycles; `fidx`, `oidx` and the timeout counter are cleared.
  - Then go to FILL.
- **FILL**
  - `net_fill`=1; `net_fill_data`=`ibuf[fidx]`, held stable between requests.
  - Each `net_word_req` pulse increments `fidx`, saturating at `N_IN-1`.
  - `net_ack_fill`=1 goes to RUN; `net_fill` drops in the same transition.
- **RUN**
  - `net_req`=1, held.
  - Each `net_out_valid` with `oidx`<`N_OUT` writes `net_out_data` to `obuf[oidx++]`. Extra strobes are ignored.
  - Exit to EMIT when `net_ack`=1 and `oidx`=`N_OUT`. Count the strobe arriving in the same cycle as ack.
- **EMIT**
  - `out_valid`=1, `out_data`=`obuf[eidx]`, `out_last`=(`eidx`=`N_OUT-1`).
  - Data holds while `out_ready`=0.
  - When the last word is accepted: `sample_cnt`++ and go to IDLE.
- **Timeout**
  - The counter runs in FILL and RUN.
  - Reaching `TIMEOUT` sets `err_timeout` and goes to ABORT, discarding the sample.
- **ABORT**
  - `net_rst`=1 for `NRST_CYC` cycles, then IDLE.
  - `sample_cnt` is unchanged.
- **Reset**
  - `rst` in any state returns to IDLE on the next edge.
  - All outputs are 0: `in_ready`, `net_rst`, `net_fill`, `net_fill_data`, `net_req`, `out_valid`, `out_data`, `out_last`, `busy`, `err_timeout`, `sample_cnt`.
  - Buffers are not cleared.
  - `net_rst` is not asserted during `rst`; the network shares `rst`.
- All outputs are registered; no combinational path from any input to any output.

## Timing
- Output of a state is valid the cycle after the transition edge.
- Minimum sample latency, from last input handshake to first `out_valid`, is 3 + `NRST_CYC` + network fill time + network run time.
- LOAD sustains one word per cycle.
- EMIT sustains one word per cycle with `out_ready`=1.
- `in_ready`=0 from NRST through EMIT; there is no overlap between samples.
- Simultaneous `net_word_req` and `net_ack_fill`: the index update is taken, then the block goes to RUN.
- Timeout counter saturates; comparison is ≥ `TIMEOUT`.

## Structure
- Shared package `nn_seq_pkg`:
  - state enum `seq_state_t`
  - default `DW`, `NRST_CYC` and `TIMEOUT` constants
  - `sample_cnt` width constant
- One natural sub-module, `nn_seq_buf`: a parameterised register-file buffer with write index and read mux. It is instantiated twice, as `ibuf` (`N_IN` entries) and `obuf` (`N_OUT` entries).
- The FSM, counters and timeout live in the top.

## Test plan
- Reset: drive stimulus with `rst`=1 for 3 cycles → every output 0, state IDLE, `in_ready`=1 after release.
- Nominal XOR: stream {0x7F, 0x00} against a network model returning 0x7F → `net_rst` high 2 cycles, network receives 0x7F then 0x00, `out_data`=0x7F with `out_last`=1, `sample_cnt`=1.
- Backpressure: hold `out_ready`=0 for 10 cycles → `out_valid` and `out_data` stable throughout; one handshake on release.
- Back-to-back: send 4 samples with no gaps → 4 outputs in order, a `net_rst` pulse before each fill, `sample_cnt`=4.
- Timeout: model never asserts `net_ack` → `err_timeout`=1 at cycle `TIMEOUT` of FILL+RUN, then an ABORT `net_rst` pulse, IDLE, no `out_valid`, `sample_cnt` unchanged.
- Reset mid-RUN: assert `rst` during RUN → IDLE next cycle, `net_req`=0; the next sample completes normally.

Source files
------------

// File: rtl/nn_seq_pkg.sv
// Shared types and defaults for the inference-network run sequencer.
// Holds the sequencer state encoding, default widths/timings and an index-width helper.
package nn_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_NRST,
        S_FILL,
        S_RUN,
        S_EMIT,
        S_ABORT
    } seq_state_t;

    localparam int DW_DEF       = 8;
    localparam int NRST_CYC_DEF = 2;
    localparam int TIMEOUT_DEF  = 255;
    localparam int SCNT_W       = 16;

    // Bits needed to hold any value 0..n inclusive (never less than 1).
    function automatic int idx_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/nn_seq_buf.sv
// Small register-file buffer: one indexed write port, one combinational read mux.
// Contents are not reset; they are always written before being read.
module nn_seq_buf
    import nn_seq_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int DW    = DW_DEF,
    parameter int IW    = idx_w(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [IW-1:0] i_widx,
    input  logic [DW-1:0] i_wdata,
    input  logic [IW-1:0] i_ridx,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int unsigned k = 0; k < unsigned'(DEPTH); k++) begin
            if (i_we && (i_widx == IW'(k))) begin
                r_mem[k] <= i_wdata;
            end
        end
    end

    always_comb begin
        o_rdata = '0;
        for (int unsigned k = 0; k < unsigned'(DEPTH); k++) begin
            if (i_ridx == IW'(k)) begin
                o_rdata = r_mem[k];
            end
        end
    end

endmodule

// File: rtl/nn_run_sequencer.sv
// Sample-level controller: buffers one input sample, re-arms and feeds the network,
// collects its results and streams them downstream, aborting on a run timeout.
module nn_run_sequencer
    import nn_seq_pkg::*;
#(
    parameter int N_IN     = 2,
    parameter int N_OUT    = 1,
    parameter int DW       = DW_DEF,
    parameter int NRST_CYC = NRST_CYC_DEF,
    parameter int TIMEOUT  = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DW-1:0]     in_data,
    output logic              net_rst,
    output logic              net_fill,
    input  logic              net_word_req,
    output logic [DW-1:0]     net_fill_data,
    input  logic              net_ack_fill,
    output logic              net_req,
    input  logic              net_ack,
    input  logic              net_out_valid,
    input  logic [DW-1:0]     net_out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DW-1:0]     out_data,
    output logic              out_last,
    output logic              busy,
    output logic              err_timeout,
    output logic [SCNT_W-1:0] sample_cnt
);

    localparam int IIW = idx_w(N_IN);
    localparam int OIW = idx_w(N_OUT);
    localparam int TW  = idx_w(TIMEOUT);
    localparam int NW  = idx_w(NRST_CYC);

    localparam logic [IIW-1:0] IN_LAST   = IIW'(N_IN - 1);
    localparam logic [OIW-1:0] OUT_LAST  = OIW'(N_OUT - 1);
    localparam logic [OIW-1:0] OUT_FULL  = OIW'(N_OUT);
    localparam logic [TW-1:0]  TO_LAST   = TW'(TIMEOUT - 1);
    localparam logic [NW-1:0]  NRST_LAST = NW'(NRST_CYC - 1);

    seq_state_t        r_state;
    seq_state_t        w_state_nxt;
    logic [IIW-1:0]    r_widx;
    logic [IIW-1:0]    r_fidx;
    logic [OIW-1:0]    r_oidx;
    logic [OIW-1:0]    r_eidx;
    logic [TW-1:0]     r_tcnt;
    logic [NW-1:0]     r_ncnt;

    logic              r_in_ready;
    logic              r_net_rst;
    logic              r_net_fill;
    logic [DW-1:0]     r_net_fill_data;
    logic              r_net_req;
    logic              r_out_valid;
    logic [DW-1:0]     r_out_data;
    logic              r_out_last;
    logic              r_busy;
    logic              r_err_timeout;
    logic [SCNT_W-1:0] r_sample_cnt;

    logic              w_in_hs;
    logic              w_out_hs;
    logic              w_to_hit;
    logic              w_nrst_done;
    logic [IIW-1:0]    w_ibuf_widx;
    logic [IIW-1:0]    w_fidx_nxt;
    logic [DW-1:0]     w_ibuf_rdata;
    logic              w_obuf_we;
    logic [OIW-1:0]    w_oidx_nxt;
    logic [OIW-1:0]    w_eidx_nxt;
    logic [DW-1:0]     w_obuf_rdata;
    logic [DW-1:0]     w_out_src;

    assign w_in_hs     = in_valid & r_in_ready;
    assign w_out_hs    = r_out_valid & out_ready;
    assign w_to_hit    = ((r_state == S_FILL) || (r_state == S_RUN)) && (r_tcnt >= TO_LAST);
    assign w_nrst_done = (r_ncnt == NRST_LAST);
    assign w_ibuf_widx = (r_state == S_LOAD) ? r_widx : '0;

    nn_seq_buf #(.DEPTH(N_IN), .DW(DW), .IW(IIW)) ibuf (
        .clk     (clk),
        .i_we    (w_in_hs),
        .i_widx  (w_ibuf_widx),
        .i_wdata (in_data),
        .i_ridx  (w_fidx_nxt),
        .o_rdata (w_ibuf_rdata)
    );

    nn_seq_buf #(.DEPTH(N_OUT), .DW(DW), .IW(OIW)) obuf (
        .clk     (clk),
        .i_we    (w_obuf_we),
        .i_widx  (r_oidx),
        .i_wdata (net_out_data),
        .i_ridx  (w_eidx_nxt),
        .o_rdata (w_obuf_rdata)
    );

    always_comb begin
        w_fidx_nxt = r_fidx;
        w_eidx_nxt = r_eidx;
        w_obuf_we  = (r_state == S_RUN) && net_out_valid && (r_oidx < OUT_FULL);
        w_oidx_nxt = w_obuf_we ? r_oidx + 1'b1 : r_oidx;
        if (r_state == S_NRST) begin
            w_fidx_nxt = '0;
            w_eidx_nxt = '0;
        end else if ((r_state == S_FILL) && net_word_req && (r_fidx < IN_LAST)) begin
            w_fidx_nxt = r_fidx + 1'b1;
        end else if ((r_state == S_EMIT) && w_out_hs && (r_eidx != OUT_LAST)) begin
            w_eidx_nxt = r_eidx + 1'b1;
        end
        // A result strobe landing on the RUN->EMIT edge is forwarded straight to out_data.
        w_out_src = (w_obuf_we && (r_oidx == w_eidx_nxt)) ? net_out_data : w_obuf_rdata;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (w_in_hs) w_state_nxt = (N_IN == 1) ? S_NRST : S_LOAD;
            S_LOAD:  if (w_in_hs && (r_widx == IN_LAST)) w_state_nxt = S_NRST;
            S_NRST:  if (w_nrst_done) w_state_nxt = S_FILL;
            S_FILL: begin
                if (w_to_hit)          w_state_nxt = S_ABORT;
                else if (net_ack_fill) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (w_to_hit)                                w_state_nxt = S_ABORT;
                else if (net_ack && (w_oidx_nxt == OUT_FULL)) w_state_nxt = S_EMIT;
            end
            S_EMIT:  if (w_out_hs && (r_eidx == OUT_LAST)) w_state_nxt = S_IDLE;
            S_ABORT: if (w_nrst_done) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_widx          <= '0;
            r_fidx          <= '0;
            r_oidx          <= '0;
            r_eidx          <= '0;
            r_tcnt          <= '0;
            r_ncnt          <= '0;
            r_in_ready      <= 1'b0;
            r_net_rst       <= 1'b0;
            r_net_fill      <= 1'b0;
            r_net_fill_data <= '0;
            r_net_req       <= 1'b0;
            r_out_valid     <= 1'b0;
            r_out_data      <= '0;
            r_out_last      <= 1'b0;
            r_busy          <= 1'b0;
            r_err_timeout   <= 1'b0;
            r_sample_cnt    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_in_hs) begin
                r_widx <= (r_state == S_LOAD) ? r_widx + 1'b1 : IIW'(1);
            end
            r_fidx <= w_fidx_nxt;
            r_eidx <= w_eidx_nxt;
            r_oidx <= (r_state == S_NRST) ? '0 : w_oidx_nxt;

            if (r_state == S_NRST) begin
                r_tcnt <= '0;
            end else if (((r_state == S_FILL) || (r_state == S_RUN)) && (r_tcnt != '1)) begin
                r_tcnt <= r_tcnt + 1'b1;
            end

            if (((r_state == S_NRST) || (r_state == S_ABORT)) && (w_state_nxt == r_state)) begin
                r_ncnt <= r_ncnt + 1'b1;
            end else begin
                r_ncnt <= '0;
            end

            // Outputs are registered from the next state so they track it exactly.
            r_in_ready      <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_LOAD);
            r_net_rst       <= (w_state_nxt == S_NRST) || (w_state_nxt == S_ABORT);
            r_net_fill      <= (w_state_nxt == S_FILL);
            r_net_fill_data <= (w_state_nxt == S_FILL) ? w_ibuf_rdata : '0;
            r_net_req       <= (w_state_nxt == S_RUN);
            r_out_valid     <= (w_state_nxt == S_EMIT);
            r_out_data      <= (w_state_nxt == S_EMIT) ? w_out_src : '0;
            r_out_last      <= (w_state_nxt == S_EMIT) && (w_eidx_nxt == OUT_LAST);
            r_busy          <= (w_state_nxt != S_IDLE);
            if (w_to_hit) begin
                r_err_timeout <= 1'b1;
            end
            if ((r_state == S_EMIT) && (w_state_nxt == S_IDLE)) begin
                r_sample_cnt <= r_sample_cnt + 1'b1;
            end
        end
    end

    assign in_ready      = r_in_ready;
    assign net_rst       = r_net_rst;
    assign net_fill      = r_net_fill;
    assign net_fill_data = r_net_fill_data;
    assign net_req       = r_net_req;
    assign out_valid     = r_out_valid;
    assign out_data      = r_out_data;
    assign out_last      = r_out_last;
    assign busy          = r_busy;
    assign err_timeout   = r_err_timeout;
    assign sample_cnt    = r_sample_cnt;

endmodule

// File: tb/tb_nn_run_sequencer.sv
// Bench for nn_run_sequencer: a behavioural network model (XOR of the received words)
// plus per-scenario tasks comparing observed streams against expected sample results.
module tb_nn_run_sequencer;

    localparam int N_IN     = 2;
    localparam int N_OUT    = 1;
    localparam int DW       = 8;
    localparam int NRST_CYC = 2;
    localparam int TIMEOUT  = 255;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          out_ready = 1'b0;
    logic          net_word_req = 1'b0;
    logic          net_ack_fill = 1'b0;
    logic          net_ack = 1'b0;
    logic          net_out_valid = 1'b0;
    logic [DW-1:0] net_out_data = '0;

    logic          in_ready, net_rst, net_fill, net_req, out_valid, out_last, busy, err_timeout;
    logic [DW-1:0] net_fill_data, out_data;
    logic [15:0]   sample_cnt;

    always #5 clk = ~clk;

    nn_run_sequencer #(
        .N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .NRST_CYC(NRST_CYC), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .net_rst(net_rst), .net_fill(net_fill), .net_word_req(net_word_req),
        .net_fill_data(net_fill_data), .net_ack_fill(net_ack_fill),
        .net_req(net_req), .net_ack(net_ack),
        .net_out_valid(net_out_valid), .net_out_data(net_out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .err_timeout(err_timeout), .sample_cnt(sample_cnt)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // network model state
    bit            m_never_ack = 1'b0;
    int            got_n = 0, run_cnt = 0, m_lat = 1, m_gap = 0;
    logic [DW-1:0] cur_x = '0;

    // observation records
    logic [DW-1:0] rx_q[$];
    logic [8:0]    out_q[$];
    int            len_q[$];
    int            n_pulses = 0, n_active = 0, n_outv = 0, cur_len = 0;
    bit            prev_nrst = 1'b0;

    // expectations
    logic [DW-1:0] exp_words[$];
    logic [8:0]    exp_out[$];
    int            exp_cnt = 0;

    // Network: takes each presented word (with random stalls), acks fill with the last
    // word request, and after a random latency returns the XOR of the words it received.
    initial begin
        forever begin
            @(negedge clk);
            net_word_req  = 1'b0;
            net_out_valid = 1'b0;
            net_out_data  = '0;
            if (rst || net_rst) begin
                got_n = 0; run_cnt = 0; cur_x = '0;
                net_ack_fill = 1'b0; net_ack = 1'b0;
                m_lat = $urandom_range(1, 4);
                m_gap = $urandom_range(0, 2);
            end else begin
                if (net_fill && !net_ack_fill && got_n < N_IN && $urandom_range(0, 3) != 0) begin
                    rx_q.push_back(net_fill_data);
                    cur_x = cur_x ^ net_fill_data;
                    got_n++;
                    net_word_req = 1'b1;
                    if (got_n == N_IN) net_ack_fill = 1'b1;
                end
                if (net_req && !net_ack && !m_never_ack) begin
                    run_cnt++;
                    if (run_cnt == m_lat) begin
                        net_out_valid = 1'b1;
                        net_out_data  = cur_x;
                    end
                    if (run_cnt == m_lat + m_gap) net_ack = 1'b1;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) out_q.push_back({out_last, out_data});
            if (out_valid) n_outv++;
            if (net_fill || net_req) n_active++;
            if (net_rst) begin
                if (!prev_nrst) n_pulses++;
                cur_len++;
            end else if (prev_nrst) begin
                len_q.push_back(cur_len);
                cur_len = 0;
            end
            prev_nrst = net_rst;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1);
    end

    task automatic send_word(input logic [DW-1:0] w, output bit ok);
        in_valid = 1'b1;
        in_data  = w;
        ok = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = DW'($urandom);
    endtask

    task automatic send_pair(input logic [DW-1:0] a, input logic [DW-1:0] b, output bit ok);
        bit ok1, ok2;
        send_word(a, ok1);
        send_word(b, ok2);
        ok = ok1 && ok2;
        exp_words.push_back(a);
        exp_words.push_back(b);
        exp_out.push_back({1'b1, a ^ b});
    endtask

    task automatic wait_outs(input int n, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (out_q.size() >= n) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (!busy) begin ok = 1'b1; break; end
        end
    endtask

    task automatic clear_records();
        rx_q.delete(); out_q.delete(); len_q.delete();
        exp_words.delete(); exp_out.delete();
        n_pulses = 0; n_active = 0; n_outv = 0;
    endtask

    task automatic test_reset();
        logic [39:0] v;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = DW'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            v = {in_ready, net_rst, net_fill, net_fill_data, net_req, out_valid, out_data,
                 out_last, busy, err_timeout, sample_cnt};
            n_checks++;
            if (v !== 40'h0) $display("FAIL reset_outputs: got %h expected %h", v, 40'h0);
            else n_pass++;
        end
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({in_ready, busy} !== 2'b10) $display("FAIL reset_release: got in_ready,busy=%b expected 10", {in_ready, busy});
        else n_pass++;
    endtask

    task automatic test_nominal();
        bit ok;
        @(posedge clk); #1;
        clear_records();
        out_ready = 1'b1;
        send_pair(8'h7F, 8'h00, ok);
        n_checks++;
        if (!ok) $display("FAIL nom_accept: got timeout expected accepted"); else n_pass++;
        wait_outs(1, ok);
        n_checks++;
        if (!ok) $display("FAIL nom_out_wait: got no output expected 1 word"); else n_pass++;
        wait_idle(ok);
        exp_cnt++;
        n_checks++;
        if (n_pulses !== 1) $display("FAIL nom_rst_pulses: got %0d expected 1", n_pulses); else n_pass++;
        n_checks++;
        if (len_q.size() != 1 || len_q[0] !== NRST_CYC)
            $display("FAIL nom_rst_len: got %0d expected %0d", (len_q.size() > 0) ? len_q[0] : -1, NRST_CYC);
        else n_pass++;
        n_checks++;
        if (rx_q.size() !== 2) $display("FAIL nom_rx_count: got %0d expected 2", rx_q.size());
        else begin
            n_pass++;
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (rx_q[i] !== exp_words[i]) $display("FAIL nom_rx_word%0d: got %h expected %h", i, rx_q[i], exp_words[i]);
                else n_pass++;
            end
        end
        n_checks++;
        if (out_q.size() < 1 || out_q[0] !== exp_out[0])
            $display("FAIL nom_out: got %h expected %h", (out_q.size() > 0) ? out_q[0] : 9'h0, exp_out[0]);
        else n_pass++;
        n_checks++;
        if (sample_cnt !== 16'(exp_cnt)) $display("FAIL nom_cnt: got %0d expected %0d", sample_cnt, exp_cnt); else n_pass++;
    endtask

    task automatic test_backpressure();
        bit ok, stable;
        @(posedge clk); #1;
        clear_records();
        out_ready = 1'b0;
        send_pair(DW'($urandom), DW'($urandom), ok);
        ok = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (out_valid) begin ok = 1'b1; break; end
        end
        n_checks++;
        if (!ok) $display("FAIL bp_valid_wait: got no out_valid expected out_valid"); else n_pass++;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!(out_valid && {out_last, out_data} === exp_out[0])) stable = 1'b0;
        end
        n_checks++;
        if (!stable) $display("FAIL bp_hold: got %b/%h expected 1/%h held", out_valid, {out_last, out_data}, exp_out[0]);
        else n_pass++;
        n_checks++;
        if (out_q.size() !== 0) $display("FAIL bp_no_hs: got %0d handshakes expected 0", out_q.size()); else n_pass++;
        @(posedge clk); #1;
        out_ready = 1'b1;
        repeat (5) @(negedge clk);
        exp_cnt++;
        n_checks++;
        if (out_q.size() !== 1 || out_q[0] !== exp_out[0])
            $display("FAIL bp_release: got %0d words first %h expected 1 word %h", out_q.size(), (out_q.size() > 0) ? out_q[0] : 9'h0, exp_out[0]);
        else n_pass++;
        n_checks++;
        if (out_valid !== 1'b0 || sample_cnt !== 16'(exp_cnt))
            $display("FAIL bp_after: got valid=%b cnt=%0d expected valid=0 cnt=%0d", out_valid, sample_cnt, exp_cnt);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        bit ok, all_ok;
        int bad;
        @(posedge clk); #1;
        clear_records();
        out_ready = 1'b1;
        all_ok = 1'b1;
        for (int s = 0; s < 4; s++) begin
            send_pair(DW'($urandom), DW'($urandom), ok);
            all_ok = all_ok && ok;
        end
        n_checks++;
        if (!all_ok) $display("FAIL b2b_accept: got timeout expected all words accepted"); else n_pass++;
        wait_outs(4, ok);
        wait_idle(ok);
        exp_cnt += 4;
        n_checks++;
        if (out_q.size() !== 4) $display("FAIL b2b_count: got %0d expected 4", out_q.size()); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            if (i < out_q.size()) begin
                n_checks++;
                if (out_q[i] !== exp_out[i]) $display("FAIL b2b_out%0d: got %h expected %h", i, out_q[i], exp_out[i]);
                else n_pass++;
            end
        end
        bad = 0;
        foreach (len_q[i]) if (len_q[i] != NRST_CYC) bad++;
        n_checks++;
        if (n_pulses !== 4 || bad !== 0) $display("FAIL b2b_rst_pulses: got %0d pulses %0d bad lengths expected 4 pulses 0 bad", n_pulses, bad);
        else n_pass++;
        bad = (rx_q.size() == exp_words.size()) ? 0 : 1;
        foreach (rx_q[i]) if (i < exp_words.size() && rx_q[i] !== exp_words[i]) bad++;
        n_checks++;
        if (bad !== 0) $display("FAIL b2b_rx_words: got %0d word mismatches expected 0", bad); else n_pass++;
        n_checks++;
        if (sample_cnt !== 16'(exp_cnt)) $display("FAIL b2b_cnt: got %0d expected %0d", sample_cnt, exp_cnt); else n_pass++;
    endtask

    task automatic test_timeout();
        bit ok, ok2;
        int bad;
        @(posedge clk); #1;
        clear_records();
        m_never_ack = 1'b1;
        send_word(DW'($urandom), ok);
        send_word(DW'($urandom), ok2);
        ok = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (err_timeout) begin ok = 1'b1; break; end
        end
        n_checks++;
        if (!ok) $display("FAIL to_flag: got err_timeout=0 expected 1"); else n_pass++;
        n_checks++;
        if (n_active !== TIMEOUT) $display("FAIL to_cycles: got %0d fill+run cycles expected %0d", n_active, TIMEOUT); else n_pass++;
        n_checks++;
        if (net_rst !== 1'b1) $display("FAIL to_abort_rst: got net_rst=%b expected 1", net_rst); else n_pass++;
        wait_idle(ok);
        repeat (2) @(negedge clk);
        bad = 0;
        foreach (len_q[i]) if (len_q[i] != NRST_CYC) bad++;
        n_checks++;
        if (n_pulses !== 2 || bad !== 0) $display("FAIL to_rst_pulses: got %0d pulses %0d bad lengths expected 2 pulses 0 bad", n_pulses, bad);
        else n_pass++;
        n_checks++;
        if (n_outv !== 0) $display("FAIL to_no_output: got %0d out_valid cycles expected 0", n_outv); else n_pass++;
        n_checks++;
        if ({err_timeout, in_ready, busy} !== 3'b110 || sample_cnt !== 16'(exp_cnt))
            $display("FAIL to_after: got err,in_ready,busy=%b cnt=%0d expected 110 cnt=%0d", {err_timeout, in_ready, busy}, sample_cnt, exp_cnt);
        else n_pass++;
        @(posedge clk); #1;
        m_never_ack = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        bit ok, ok2;
        @(posedge clk); #1;
        clear_records();
        m_never_ack = 1'b1;
        send_word(DW'($urandom), ok);
        send_word(DW'($urandom), ok2);
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (net_req) begin ok = 1'b1; break; end
        end
        n_checks++;
        if (!ok) $display("FAIL mr_reach_run: got net_req=0 expected 1"); else n_pass++;
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_never_ack = 1'b0;
        exp_cnt = 0;
        @(negedge clk);
        n_checks++;
        if ({net_req, busy, err_timeout} !== 3'b000 || sample_cnt !== 16'h0)
            $display("FAIL mr_reset: got req,busy,err=%b cnt=%0d expected 000 cnt=0", {net_req, busy, err_timeout}, sample_cnt);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL mr_ready: got %b expected 1", in_ready); else n_pass++;
        @(posedge clk); #1;
        clear_records();
        send_pair(DW'($urandom), DW'($urandom), ok);
        wait_outs(1, ok);
        wait_idle(ok2);
        exp_cnt++;
        n_checks++;
        if (out_q.size() !== 1 || out_q[0] !== exp_out[0])
            $display("FAIL mr_next_sample: got %0d words first %h expected 1 word %h", out_q.size(), (out_q.size() > 0) ? out_q[0] : 9'h0, exp_out[0]);
        else n_pass++;
        n_checks++;
        if (sample_cnt !== 16'(exp_cnt)) $display("FAIL mr_cnt: got %0d expected %0d", sample_cnt, exp_cnt); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_backpressure();
        test_back_to_back();
        test_timeout();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
